// File: rtl/frame_param_latch_pkg.sv
// Shared types and defaults for the render-domain parameter latch.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frame_param_latch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    PENDING  = 2'd2
  } param_state_t;

  localparam int DEFAULT_STABLE_CYCLES = 4;

endpackage

// File: rtl/frame_param_latch_change_detector.sv
// Tracks the previous sync word and how long it has been unchanged.
// Latency: stable_o rises STABLE_CYCLES+1 cycles after a new value first appears.
// Backpressure: none; samples every cycle.
// Ports: clk, rst (async active-high), sync_in_i (word from synchronizer),
//        prev_o (last-cycle word), stable_o (word unchanged long enough).
module param_change_detector
  import frame_param_latch_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sync_in_i,
  output logic [WIDTH-1:0] prev_o,
  output logic             stable_o
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any bit movement restarts qualification; otherwise count up and hold at max.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_in_i != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= sync_in_i;
      cnt_q  <= cnt_d;
    end
  end

  assign prev_o   = prev_q;
  assign stable_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/frame_param_latch.sv
// Qualifies a CDC-synchronized parameter word and applies it only at frame boundaries.
// Latency: first commit at cycle STABLE_CYCLES+2; later values pend from STABLE_CYCLES+2
//          and appear the cycle after the accepted frame_start.
// Backpressure: none; a newer value supersedes a staged one, which is then dropped.
// Ports: clk, rst (async active-high), sync_in, frame_start (frame pulse),
//        param_out, param_valid, update_pulse, pending.
module frame_param_latch
  import frame_param_latch_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sync_in,
  input  logic             frame_start,
  output logic [WIDTH-1:0] param_out,
  output logic             param_valid,
  output logic             update_pulse,
  output logic             pending
);

  param_state_t     state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] staged_q, staged_d;
  logic             valid_q, valid_d;
  logic             pulse_q, pulse_d;
  logic             pend_q, pend_d;

  logic [WIDTH-1:0] prev_in;
  logic             stable;

  param_change_detector #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_detector (
    .clk       (clk),
    .rst       (rst),
    .sync_in_i (sync_in),
    .prev_o    (prev_in),
    .stable_o  (stable)
  );

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    staged_d = staged_q;
    valid_d  = valid_q;
    pulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!valid_q || (sync_in != out_q)) begin
          state_d = SETTLING;
        end
      end
      SETTLING: begin
        if (stable) begin
          if (valid_q && (prev_in == out_q)) begin
            // Excursion came back to the committed word: nothing to apply.
            state_d = IDLE;
          end else if (!valid_q) begin
            // Nothing rendered yet, so no frame boundary to wait for.
            out_d   = prev_in;
            valid_d = 1'b1;
            pulse_d = 1'b1;
            state_d = IDLE;
          end else begin
            staged_d = prev_in;
            state_d  = PENDING;
          end
        end
      end
      PENDING: begin
        // Commit takes priority over a same-cycle input change; IDLE re-detects it.
        if (frame_start) begin
          out_d   = staged_q;
          pulse_d = 1'b1;
          state_d = IDLE;
        end else if (sync_in != staged_q) begin
          state_d = SETTLING;
        end
      end
      default: state_d = IDLE;
    endcase
    pend_d = (state_d == PENDING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      staged_q <= '0;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      staged_q <= staged_d;
      valid_q  <= valid_d;
      pulse_q  <= pulse_d;
      pend_q   <= pend_d;
    end
  end

  assign param_out    = out_q;
  assign param_valid  = valid_q;
  assign update_pulse = pulse_q;
  assign pending      = pend_q;

endmodule

// File: tb/tb_frame_param_latch.sv
// Bench for frame_param_latch: directed scenarios plus randomized word/frame traffic,
// checked every cycle against a history-based reference model.
module tb_frame_param_latch;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] sync_in = '0;
  logic         frame_start = 1'b0;
  logic [W-1:0] param_out;
  logic         param_valid;
  logic         update_pulse;
  logic         pending;

  frame_param_latch #(.WIDTH(W), .STABLE_CYCLES(S)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .sync_in      (sync_in),
    .frame_start  (frame_start),
    .param_out    (param_out),
    .param_valid  (param_valid),
    .update_pulse (update_pulse),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: stability is judged from a window of raw input history.
  logic [W-1:0] m_out, m_staged;
  logic         m_valid, m_pulse, m_pend;
  int           m_mode;  // 0 waiting for a difference, 1 qualifying, 2 staged
  logic [W-1:0] hist[$];
  logic         seen_pend, seen_pulse;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out = '0; m_staged = '0; m_valid = 1'b0; m_pulse = 1'b0; m_pend = 1'b0;
    m_mode = 0;
    hist.delete();
    hist.push_back('0);  // register contents right after reset
  endtask

  task automatic m_step(input logic [W-1:0] x, input logic fs);
    logic         st;
    logic [W-1:0] pv;
    int           nm;
    // Stable when the last S+1 observed words are identical.
    st = (hist.size() == S + 1);
    foreach (hist[i]) if (hist[i] != hist[0]) st = 1'b0;
    pv = hist[hist.size()-1];
    nm = m_mode;
    m_pulse = 1'b0;
    if (m_mode == 0) begin
      if (!m_valid || x != m_out) nm = 1;
    end else if (m_mode == 1) begin
      if (st) begin
        if (m_valid && pv == m_out) nm = 0;
        else if (!m_valid) begin
          m_out = pv; m_valid = 1'b1; m_pulse = 1'b1; nm = 0;
        end else begin
          m_staged = pv; nm = 2;
        end
      end
    end else begin
      if (fs) begin
        m_out = m_staged; m_pulse = 1'b1; nm = 0;
      end else if (x != m_staged) nm = 1;
    end
    m_mode = nm;
    m_pend = (nm == 2);
    hist.push_back(x);
    if (hist.size() > S + 1) void'(hist.pop_front());
  endtask

  task automatic compare_all();
    chk("param_out", param_out, m_out);
    chk("param_valid", 32'(param_valid), 32'(m_valid));
    chk("update_pulse", 32'(update_pulse), 32'(m_pulse));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  // One cycle: drive at negedge, model at posedge, compare at next negedge.
  task automatic cyc(input logic [W-1:0] x, input logic fs);
    sync_in = x;
    frame_start = fs;
    @(posedge clk);
    m_step(x, fs);
    @(negedge clk);
    compare_all();
    seen_pend  = seen_pend | pending;
    seen_pulse = seen_pulse | update_pulse;
  endtask

  task automatic hold(input logic [W-1:0] x, input int n);
    for (int i = 0; i < n; i++) cyc(x, 1'b0);
  endtask

  // Asserts reset between edges, checks it clears without a clock, releases at negedge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_out", param_out, 32'h0);
    chk("rst_valid", 32'(param_valid), 32'h0);
    chk("rst_pulse", 32'(update_pulse), 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    int           len;
    m_reset();
    #1;
    do_reset();

    // First commit without a frame boundary.
    hold(32'h1234, 5);
    chk("t1_valid_c5", 32'(param_valid), 32'h0);
    cyc(32'h1234, 1'b0);
    chk("t1_out_c6", param_out, 32'h1234);
    chk("t1_valid_c6", 32'(param_valid), 32'h1);
    chk("t1_pulse_c6", 32'(update_pulse), 32'h1);
    cyc(32'h1234, 1'b0);
    chk("t1_pulse_c7", 32'(update_pulse), 32'h0);
    hold(32'h1234, 3);

    // Framed update.
    hold(32'hABCD, 6);
    chk("t2_pend_c6", 32'(pending), 32'h1);
    chk("t2_out_c6", param_out, 32'h1234);
    hold(32'hABCD, 4);
    cyc(32'hABCD, 1'b1);
    chk("t2_out_c11", param_out, 32'hABCD);
    chk("t2_pulse_c11", 32'(update_pulse), 32'h1);
    chk("t2_pend_c11", 32'(pending), 32'h0);
    hold(32'hABCD, 3);

    // Incoherent bus with frame_start every cycle.
    for (int i = 0; i < 18; i++)
      cyc((i < 12 && (i % 2) == 1) ? 32'h0F0F : 32'hF0F0, 1'b1);
    chk("t3_out_c18", param_out, 32'hABCD);
    cyc(32'hF0F0, 1'b1);
    chk("t3_out_c19", param_out, 32'hF0F0);
    hold(32'hF0F0, 2);
    hold(32'h1234, 6);
    cyc(32'h1234, 1'b1);
    hold(32'h1234, 2);

    // Revert to the committed word.
    seen_pend = 1'b0; seen_pulse = 1'b0;
    hold(32'h5555, 2);
    hold(32'h1234, 8);
    chk("t4_seen_pend", 32'(seen_pend), 32'h0);
    chk("t4_seen_pulse", 32'(seen_pulse), 32'h0);
    chk("t4_out", param_out, 32'h1234);

    // Supersede a staged value.
    hold(32'hAAAA, 6);
    chk("t5_pend_a", 32'(pending), 32'h1);
    cyc(32'hBBBB, 1'b0);
    chk("t5_pend_drop", 32'(pending), 32'h0);
    hold(32'hBBBB, 8);
    chk("t5_pend_b", 32'(pending), 32'h1);
    chk("t5_out_pre", param_out, 32'h1234);
    cyc(32'hBBBB, 1'b1);
    chk("t5_out_b", param_out, 32'hBBBB);

    // frame_start colliding with a change.
    hold(32'hAAAA, 6);
    cyc(32'hCCCC, 1'b1);
    chk("t5_out_a", param_out, 32'hAAAA);
    chk("t5_pulse_a", 32'(update_pulse), 32'h1);
    hold(32'hCCCC, 7);
    chk("t5_pend_c", 32'(pending), 32'h1);
    chk("t5_out_c", param_out, 32'hAAAA);

    // Reset while a value is pending, then first-commit timing again.
    do_reset();
    hold(32'h1234, 5);
    chk("t6_valid_c5", 32'(param_valid), 32'h0);
    cyc(32'h1234, 1'b0);
    chk("t6_out_c6", param_out, 32'h1234);
    chk("t6_pulse_c6", 32'(update_pulse), 32'h1);

    // Randomized traffic.
    for (int seg = 0; seg < 250; seg++) begin
      case ($urandom_range(0, 4))
        0: v = 32'h1234;
        1: v = 32'hABCD;
        2: v = m_out ^ (32'h1 << $urandom_range(0, 31));
        3: v = m_out;
        default: v = $urandom;
      endcase
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) cyc(v, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
